// File: rtl/matrix_bank_pkg.sv
// matrix_bank_pkg
// Shared encodings for the matrix register bank and the multiply controller that
// drives it: access-type codes, matrix-select codes, bank FSM state codes, and a
// helper that decides whether a request can be served.
package matrix_bank_pkg;

    // Access type (in_type)
    localparam logic [1:0] CELL      = 2'b00;
    localparam logic [1:0] ROW       = 2'b01;
    localparam logic [1:0] COL       = 2'b10;
    localparam logic [1:0] TYPE_RSVD = 2'b11;

    // Matrix select (in_matrix)
    localparam logic [1:0] MAT_A    = 2'b00;
    localparam logic [1:0] MAT_B    = 2'b01;
    localparam logic [1:0] MAT_C    = 2'b10;
    localparam logic [1:0] MAT_RSVD = 2'b11;

    // Bank FSM states
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GATHER = 2'b01;
    localparam logic [1:0] RESP   = 2'b10;

    // A column access only uses address % size, so it can never index outside the
    // matrix; cell and row accesses need the address inside size*size.
    function automatic logic request_ok(input logic [1:0] req_type,
                                        input logic [1:0] req_matrix,
                                        input logic       addr_oob);
        return (req_type != TYPE_RSVD) && (req_matrix != MAT_RSVD) &&
               !(addr_oob && (req_type != COL));
    endfunction

endpackage

// File: rtl/matrix_cell_array.sv
// matrix_cell_array
// Flat storage for the three size x size matrices (A, B, C), cell_width bits per cell.
// Ports:
//   in_clk, in_reset         clock, synchronous active-high clear of every cell
//   in_rd_matrix/in_rd_index combinational single-cell read select (index = row*size+col)
//   out_rd_data              selected cell; 0 for a reserved matrix or out-of-range index
//   in_wr_en                 write strobe (caller has already validated the request)
//   in_wr_type               CELL, ROW or COL write mode
//   in_wr_matrix             target matrix
//   in_wr_address            cell index; row = address/size, column = address%size
//   in_wr_data               packed write data, slot k at [k*cell_width +: cell_width]
module matrix_cell_array
    import matrix_bank_pkg::*;
#(
    parameter int unsigned size          = 4,
    parameter int unsigned cell_width    = 8,
    parameter int unsigned address_width = 8,
    parameter int unsigned width         = cell_width * size
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic [1:0]               in_rd_matrix,
    input  logic [address_width-1:0] in_rd_index,
    output logic [cell_width-1:0]    out_rd_data,
    input  logic                     in_wr_en,
    input  logic [1:0]               in_wr_type,
    input  logic [1:0]               in_wr_matrix,
    input  logic [address_width-1:0] in_wr_address,
    input  logic [width-1:0]         in_wr_data
);

    localparam int unsigned Cells = size * size;
    localparam int unsigned Total = 3 * Cells;

    logic [cell_width-1:0]    cells_q [Total];
    logic [address_width-1:0] wr_row;
    logic [address_width-1:0] wr_col;

    assign wr_row = in_wr_address / address_width'(size);
    assign wr_col = in_wr_address % address_width'(size);

    always_comb begin
        out_rd_data = '0;
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < Cells; i++) begin
                if ((in_rd_matrix == 2'(m)) && (in_rd_index == address_width'(i))) begin
                    out_rd_data = cells_q[m * Cells + i];
                end
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            for (int k = 0; k < Total; k++) begin
                cells_q[k] <= '0;
            end
        end else if (in_wr_en) begin
            for (int m = 0; m < 3; m++) begin
                for (int i = 0; i < Cells; i++) begin
                    if (in_wr_matrix == 2'(m)) begin
                        case (in_wr_type)
                            CELL: if (in_wr_address == address_width'(i))
                                cells_q[m * Cells + i] <= in_wr_data[cell_width-1:0];
                            // Row write: cell j of the row takes slot j
                            ROW: if (wr_row == address_width'(i / size))
                                cells_q[m * Cells + i] <=
                                    in_wr_data[(i % size) * cell_width +: cell_width];
                            // Column write: cell k of the column takes slot k
                            COL: if (wr_col == address_width'(i % size))
                                cells_q[m * Cells + i] <=
                                    in_wr_data[(i / size) * cell_width +: cell_width];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: rtl/matrix_register_bank.sv
// matrix_register_bank
// Serves cell/row/column reads of matrices A, B, C for the multiply controller and
// absorbs its writes. Reads are gathered one cell per cycle, then presented with a
// one-cycle out_data_ready pulse. Writes commit immediately in IDLE.
// Ports:
//   in_clk, in_reset   clock, synchronous active-high reset
//   in_reg_address     cell index (row*size+col)
//   in_type            00 cell, 01 row, 10 column, 11 reserved
//   in_matrix          00 A, 01 B, 10 C, 11 reserved
//   in_read_en         read request (level, sampled only in IDLE)
//   in_write_en        write request (sampled only in IDLE)
//   in_data            packed write data
//   out_data           read data, held until the next response
//   out_data_ready     one-cycle pulse marking out_data valid
//   out_busy           high while gathering or responding
//   out_error          sticky error flag, cleared only by reset
module matrix_register_bank
    import matrix_bank_pkg::*;
#(
    parameter int unsigned size          = 4,
    parameter int unsigned cell_width    = 8,
    parameter int unsigned address_width = 8,
    parameter int unsigned width         = cell_width * size
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic [address_width-1:0] in_reg_address,
    input  logic [1:0]               in_type,
    input  logic [1:0]               in_matrix,
    input  logic                     in_read_en,
    input  logic                     in_write_en,
    input  logic [width-1:0]         in_data,
    output logic [width-1:0]         out_data,
    output logic                     out_data_ready,
    output logic                     out_busy,
    output logic                     out_error
);

    localparam int unsigned Cells = size * size;
    localparam int unsigned IdxW  = (size > 1) ? $clog2(size) : 1;

    logic [1:0]               state_q, state_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [1:0]               type_q, type_d;
    logic [1:0]               matrix_q, matrix_d;
    logic                     bad_q, bad_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [width-1:0]         asm_q, asm_d;
    logic [width-1:0]         data_q, data_d;
    logic                     error_q, error_d;

    logic                     addr_oob;
    logic                     req_ok;
    logic                     wr_commit;
    logic [address_width-1:0] row_base;
    logic [address_width-1:0] col_off;
    logic [address_width-1:0] idx_ext;
    logic [address_width-1:0] gather_index;
    logic                     gather_last;
    logic [cell_width-1:0]    rd_data;
    logic [width-1:0]         asm_next;

    assign addr_oob  = in_reg_address >= address_width'(Cells);
    assign req_ok    = request_ok(in_type, in_matrix, addr_oob);
    assign wr_commit = (state_q == IDLE) && in_write_en && req_ok;

    // Cell fetched this GATHER cycle, from the captured request
    assign row_base = (addr_q / address_width'(size)) * address_width'(size);
    assign col_off  = addr_q % address_width'(size);
    assign idx_ext  = address_width'(idx_q);

    always_comb begin
        case (type_q)
            ROW:     gather_index = row_base + idx_ext;
            COL:     gather_index = idx_ext * address_width'(size) + col_off;
            default: gather_index = addr_q;
        endcase
    end

    // Only row/column reads span size cells; cell (and reserved-type) reads take one
    assign gather_last = ((type_q != ROW) && (type_q != COL)) ||
                         (idx_q == IdxW'(size - 1));

    always_comb begin
        asm_next = asm_q;
        asm_next[int'(idx_q) * cell_width +: cell_width] = rd_data;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        type_d   = type_q;
        matrix_d = matrix_q;
        bad_d    = bad_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        data_d   = data_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (in_write_en) begin
                    // Write wins over a simultaneous read; the read is dropped
                    if (!req_ok || in_read_en) error_d = 1'b1;
                end else if (in_read_en) begin
                    addr_d   = in_reg_address;
                    type_d   = in_type;
                    matrix_d = in_matrix;
                    // A bad read still completes (with zero data) so the requester never hangs
                    bad_d    = !req_ok;
                    if (!req_ok) error_d = 1'b1;
                    idx_d    = '0;
                    asm_d    = '0;
                    state_d  = GATHER;
                end
            end
            GATHER: begin
                if (in_write_en) error_d = 1'b1;
                asm_d = asm_next;
                idx_d = idx_q + 1'b1;
                if (gather_last) begin
                    data_d  = bad_q ? '0 : asm_next;
                    state_d = RESP;
                end
            end
            RESP: begin
                // in_read_en is typically still high here; it is deliberately ignored
                if (in_write_en) error_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            type_q   <= CELL;
            matrix_q <= MAT_A;
            bad_q    <= 1'b0;
            idx_q    <= '0;
            asm_q    <= '0;
            data_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            type_q   <= type_d;
            matrix_q <= matrix_d;
            bad_q    <= bad_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            data_q   <= data_d;
            error_q  <= error_d;
        end
    end

    matrix_cell_array #(
        .size          (size),
        .cell_width    (cell_width),
        .address_width (address_width),
        .width         (width)
    ) u_cells (
        .in_clk        (in_clk),
        .in_reset      (in_reset),
        .in_rd_matrix  (matrix_q),
        .in_rd_index   (gather_index),
        .out_rd_data   (rd_data),
        .in_wr_en      (wr_commit),
        .in_wr_type    (in_type),
        .in_wr_matrix  (in_matrix),
        .in_wr_address (in_reg_address),
        .in_wr_data    (in_data)
    );

    assign out_data       = data_q;
    assign out_data_ready = (state_q == RESP);
    assign out_busy       = (state_q != IDLE);
    assign out_error      = error_q;

endmodule

// File: tb/tb_matrix_register_bank.sv
// tb_matrix_register_bank
// Directed, table-driven bench for matrix_register_bank (size 4, 8-bit cells), plus
// hand-written sequences for held read requests, error handling and mid-gather reset.
module tb_matrix_register_bank;
    import matrix_bank_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  addr = '0;
    logic [1:0]  typ = CELL;
    logic [1:0]  mat = MAT_A;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] out_data;
    logic        out_data_ready;
    logic        out_busy;
    logic        out_error;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    matrix_register_bank #(
        .size          (4),
        .cell_width    (8),
        .address_width (8),
        .width         (32)
    ) dut (
        .in_clk         (clk),
        .in_reset       (reset),
        .in_reg_address (addr),
        .in_type        (typ),
        .in_matrix      (mat),
        .in_read_en     (rd),
        .in_write_en    (wr),
        .in_data        (wdata),
        .out_data       (out_data),
        .out_data_ready (out_data_ready),
        .out_busy       (out_busy),
        .out_error      (out_error)
    );

    typedef struct {
        bit          is_wr;
        logic [1:0]  t;
        logic [1:0]  m;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] t, input logic [1:0] m, input logic [7:0] a,
                            input logic [31:0] d);
        @(negedge clk);
        typ = t; mat = m; addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // Returns read data and the number of edges from acceptance to the ready pulse
    task automatic do_read(input logic [1:0] t, input logic [1:0] m, input logic [7:0] a,
                           output logic [31:0] d, output int lat);
        @(negedge clk);
        typ = t; mat = m; addr = a; rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        lat = 0;
        d = '0;
        while (!out_data_ready && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_data_ready) check("read_timeout", 32'd0, 32'd1);
        else d = out_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got;
        int          lat;
        int          pulses;

        vecs[0]  = '{0, ROW,  MAT_A, 8'd4,  32'h0,        32'h0,        4};
        vecs[1]  = '{1, ROW,  MAT_A, 8'd4,  32'h04030201, 32'h0,        0};
        vecs[2]  = '{0, ROW,  MAT_A, 8'd4,  32'h0,        32'h04030201, 4};
        vecs[3]  = '{0, CELL, MAT_A, 8'd5,  32'h0,        32'h00000002, 1};
        vecs[4]  = '{1, ROW,  MAT_B, 8'd0,  32'h03020100, 32'h0,        0};
        vecs[5]  = '{1, ROW,  MAT_B, 8'd5,  32'h13121110, 32'h0,        0};
        vecs[6]  = '{1, ROW,  MAT_B, 8'd10, 32'h23222120, 32'h0,        0};
        vecs[7]  = '{1, ROW,  MAT_B, 8'd15, 32'h33323130, 32'h0,        0};
        vecs[8]  = '{0, COL,  MAT_B, 8'd2,  32'h0,        32'h32221202, 4};
        vecs[9]  = '{0, ROW,  MAT_B, 8'd13, 32'h0,        32'h33323130, 4};
        vecs[10] = '{1, CELL, MAT_A, 8'd15, 32'hABCDEFEE, 32'h0,        0};
        vecs[11] = '{0, COL,  MAT_A, 8'd7,  32'h0,        32'hEE000400, 4};
        vecs[12] = '{1, COL,  MAT_C, 8'd1,  32'hD4C3B2A1, 32'h0,        0};
        vecs[13] = '{0, ROW,  MAT_C, 8'd6,  32'h0,        32'h0000B200, 4};
        vecs[14] = '{0, CELL, MAT_C, 8'd9,  32'h0,        32'h000000C3, 1};
        vecs[15] = '{0, CELL, MAT_B, 8'd6,  32'h0,        32'h00000012, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  out_data, 32'h0);
        check("reset_ready", 32'(out_data_ready), 32'd0);
        check("reset_busy",  32'(out_busy), 32'd0);
        check("reset_error", 32'(out_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].t, vecs[i].m, vecs[i].a, vecs[i].d);
            end else begin
                do_read(vecs[i].t, vecs[i].m, vecs[i].a, got, lat);
                check($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
                check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            end
        end
        check("table_error", 32'(out_error), 32'd0);

        // Cell write, then a read whose request is held through the pulse cycle
        do_write(CELL, MAT_C, 8'd6, 32'hFFFFFF5A);
        @(negedge clk);
        typ = CELL; mat = MAT_C; addr = 8'd6; rd = 1'b1;
        pulses = 0;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_data_ready) begin
                pulses++;
                got = out_data;
            end
            if (i == 2) rd = 1'b0;
        end
        check("held_read_pulses", 32'(pulses), 32'd1);
        check("held_read_data", got, 32'h0000005A);
        check("held_read_error", 32'(out_error), 32'd0);

        // Reserved matrix read completes with zero data and raises the error flag
        do_read(CELL, MAT_RSVD, 8'd0, got, lat);
        check("rsvd_read_data", got, 32'h0);
        check("rsvd_read_latency", 32'(lat), 32'd1);
        check("rsvd_read_error", 32'(out_error), 32'd1);

        // Write arriving during GATHER must be dropped
        @(negedge clk);
        typ = ROW; mat = MAT_A; addr = 8'd0; rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        typ = CELL; addr = 8'd0; wdata = 32'h00000077; wr = 1'b1;
        @(posedge clk);
        #1 wr = 1'b0;
        lat = 1;
        while (!out_data_ready && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("gather_wr_ready", 32'(out_data_ready), 32'd1);
        check("gather_wr_row_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        do_read(CELL, MAT_A, 8'd0, got, lat);
        check("gather_wr_dropped", got, 32'h0);

        // Reset during the 2nd GATHER cycle of a row read
        do_read(ROW, MAT_A, 8'd4, got, lat);
        check("pre_reset_row", got, 32'h04030201);
        @(negedge clk);
        typ = ROW; mat = MAT_A; addr = 8'd4; rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 32'(out_data_ready), 32'd0);
        check("abort_data",  out_data, 32'h0);
        check("abort_busy",  32'(out_busy), 32'd0);
        check("abort_error", 32'(out_error), 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_data_ready) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        do_read(ROW, MAT_A, 8'd4, got, lat);
        check("post_reset_row", got, 32'h0);
        check("post_reset_latency", 32'(lat), 32'd4);
        do_read(CELL, MAT_C, 8'd6, got, lat);
        check("post_reset_cell", got, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
